// File: rtl/qdec_pkg.sv
// qdec_pkg: shared types and constants for the quadrature decoder.
//   phase_t  - decoded {A,B} phase, named in forward rotation order
//   state_t  - decoder state machine encoding
//   DIR_FWD / DIR_REV - values driven on dir
//   phase_fwd() - phase that follows a given phase in forward rotation
package qdec_pkg;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Forward rotation is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic phase_t phase_fwd(input phase_t p);
    case (p)
      PH_00:   return PH_01;
      PH_01:   return PH_11;
      PH_11:   return PH_10;
      default: return PH_00;
    endcase
  endfunction

endpackage

// File: rtl/qdec_sync_filter.sv
// qdec_sync_filter: one quadrature channel front end.
//   Two-flop synchronizer, optionally followed by a glitch filter that only
//   accepts a new level after FILT_LEN consecutive synchronized samples.
//   Optional feature macro: QDEC_GLITCH_FILTER_EN (filter present when defined).
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   din   in   raw channel input, asynchronous to clk
//   dout  out  accepted channel level
//   vld   out  dout carries a real sample taken after reset release
import qdec_pkg::*;

module qdec_sync_filter
`ifdef QDEC_GLITCH_FILTER_EN
  #(parameter int unsigned FILT_LEN = 4)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic vld
);

  logic s1, s2;
  logic v1, v2;

  // v1/v2 travel alongside s1/s2 so the decoder can tell a real sample from
  // the reset value still sitting in the synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      v1 <= 1'b1;
      v2 <= v1;
    end
  end

`ifdef QDEC_GLITCH_FILTER_EN
  localparam logic [7:0] CNT_TC = 8'(FILT_LEN - 1);

  logic [7:0] cnt;
  logic       acc;
  logic       acc_vld;

  // The first valid sample is taken as-is so a static input level after
  // reset is not delayed by (or mistaken for) a filtered edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 8'd0;
      acc     <= 1'b0;
      acc_vld <= 1'b0;
    end else if (!acc_vld) begin
      if (v2) begin
        acc     <= s2;
        acc_vld <= 1'b1;
      end
    end else if (s2 == acc) begin
      cnt <= 8'd0;
    end else if (cnt == CNT_TC) begin
      acc <= s2;
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign dout = acc;
  assign vld  = acc_vld;
`else
  assign dout = s2;
  assign vld  = v2;
`endif

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature (A/B) edge decoder producing step/dir pulses.
//   Optional feature macro: QDEC_GLITCH_FILTER_EN enables a per-channel glitch
//   filter of FILT_LEN samples; without it FILT_LEN has no effect.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   a_in/b_in  in   quadrature channels, asynchronous to clk
//   err_clr    in   synchronous clear of err_sticky
//   step       out  one-cycle pulse per valid quadrature edge
//   dir        out  1 = forward, 0 = reverse; held between steps
//   err        out  one-cycle pulse on a two-bit (illegal) phase change
//   err_sticky out  latched error flag
//   phase      out  current decoded phase {A,B}
//
// state    | meaning
// ST_INIT  | waiting for the first accepted phase; loads it without step/err
// ST_TRACK | compares accepted phase with the stored one every cycle
import qdec_pkg::*;

module quad_decoder #(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       err_clr,
  output logic       step,
  output logic       dir,
  output logic       err,
  output logic       err_sticky,
  output logic [1:0] phase
);

  logic a_acc, b_acc;
  logic a_vld, b_vld;

`ifdef QDEC_GLITCH_FILTER_EN
  qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_chan_a (
    .clk (clk), .rst (rst), .din (a_in), .dout (a_acc), .vld (a_vld)
  );
  qdec_sync_filter #(.FILT_LEN(FILT_LEN)) u_chan_b (
    .clk (clk), .rst (rst), .din (b_in), .dout (b_acc), .vld (b_vld)
  );
`else
  qdec_sync_filter u_chan_a (
    .clk (clk), .rst (rst), .din (a_in), .dout (a_acc), .vld (a_vld)
  );
  qdec_sync_filter u_chan_b (
    .clk (clk), .rst (rst), .din (b_in), .dout (b_acc), .vld (b_vld)
  );
`endif

  state_t state_q, state_nxt;
  phase_t phase_q, phase_nxt;
  phase_t ph_in;
  logic   step_nxt, err_nxt, dir_nxt, sticky_nxt;

  assign ph_in = phase_t'({a_acc, b_acc});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      phase_q    <= PH_00;
      step       <= 1'b0;
      err        <= 1'b0;
      dir        <= DIR_FWD;
      err_sticky <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      phase_q    <= phase_nxt;
      step       <= step_nxt;
      err        <= err_nxt;
      dir        <= dir_nxt;
      err_sticky <= sticky_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    phase_nxt  = phase_q;
    step_nxt   = 1'b0;
    err_nxt    = 1'b0;
    dir_nxt    = dir;
    // The registered err pulse sets the flag, so a clear in the same cycle
    // as a visible err pulse loses.
    sticky_nxt = err | (err_sticky & ~err_clr);
    case (state_q)
      ST_INIT: begin
        if (a_vld && b_vld) begin
          phase_nxt = ph_in;
          state_nxt = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (ph_in == phase_fwd(phase_q)) begin
          step_nxt = 1'b1;
          dir_nxt  = DIR_FWD;
        end else if (phase_fwd(ph_in) == phase_q) begin
          step_nxt = 1'b1;
          dir_nxt  = DIR_REV;
        end else if (ph_in != phase_q) begin
          err_nxt = 1'b1;
        end
        phase_nxt = ph_in;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign phase = phase_q;

endmodule
